// File: rtl/rx_pkt_gen_rd_ctrl_pkg.sv
// rx_pkt_gen_rd_ctrl_pkg
// Shared constants for the PHY-emulator receive read path: FSM state
// encodings, RAM read latency, output word geometry and a lane-insert helper.
// No ports (package).
package rx_pkt_gen_rd_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  localparam int RD_LATENCY = 2;
  localparam int WORD_W     = 64;
  localparam int LANES      = 8;

  // Return word w with byte b placed in the given lane (lane 0 = bits [7:0]).
  function automatic logic [WORD_W-1:0] put_byte(input logic [WORD_W-1:0] w,
                                                 input logic [2:0]        lane,
                                                 input logic [7:0]        b);
    logic [WORD_W-1:0] r;
    r = w;
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/rx_pkt_gen_rd_ctrl_if.sv
// rx_pkt_gen_rd_ctrl_if
// MAC RX word bus: 64-bit data with valid, SOP/EOP framing and the count of
// valid bytes in the EOP word (0 means 8).
//   master : packet generator side (drives everything)
//   slave  : MAC RX side (samples everything; no backpressure)
interface rx_pkt_gen_rd_ctrl_if;
  import rx_pkt_gen_rd_ctrl_pkg::*;

  logic [WORD_W-1:0] rx_data;
  logic              rx_val;
  logic              rx_sop;
  logic              rx_eop;
  logic [2:0]        rx_mod;

  modport master (output rx_data, output rx_val, output rx_sop,
                  output rx_eop, output rx_mod);
  modport slave  (input rx_data, input rx_val, input rx_sop,
                  input rx_eop, input rx_mod);
endinterface

// File: rtl/rx_pkt_gen_rd_ctrl_byte_packer.sv
// rx_pkt_byte_packer
// Packs a stream of captured RAM bytes into 64-bit words. Byte n lands in
// lane n mod 8; a word is emitted the cycle after lane 7 fills or the packet's
// last byte arrives. Unfilled lanes of the EOP word are zero.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   byte_val        : byte_data is a captured packet byte this cycle
//   byte_data       : captured byte
//   byte_last       : this byte is the packet's last byte
//   first_of_pkt    : this byte is the packet's first byte
//   rx_data..rx_mod : registered word output with framing
module rx_pkt_byte_packer
  import rx_pkt_gen_rd_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_val,
  input  logic [7:0]        byte_data,
  input  logic              byte_last,
  input  logic              first_of_pkt,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_val,
  output logic              rx_sop,
  output logic              rx_eop,
  output logic [2:0]        rx_mod
);

  logic [WORD_W-1:0] acc_r;
  logic [2:0]        lane_r;
  logic              sop_pend_r;

  // Lane accumulation and word emission.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r      <= {WORD_W{1'b0}};
      lane_r     <= 3'd0;
      sop_pend_r <= 1'b0;
      rx_data    <= {WORD_W{1'b0}};
      rx_val     <= 1'b0;
      rx_sop     <= 1'b0;
      rx_eop     <= 1'b0;
      rx_mod     <= 3'd0;
    end else begin
      rx_val <= 1'b0;
      rx_sop <= 1'b0;
      rx_eop <= 1'b0;
      rx_mod <= 3'd0;
      if (byte_val) begin
        if ((lane_r == 3'd7) || byte_last) begin
          rx_data    <= put_byte(acc_r, lane_r, byte_data);
          rx_val     <= 1'b1;
          rx_sop     <= sop_pend_r | first_of_pkt;
          rx_eop     <= byte_last;
          // lane+1 wraps to 0 for a full word, which encodes "8 bytes".
          rx_mod     <= byte_last ? (lane_r + 3'd1) : 3'd0;
          acc_r      <= {WORD_W{1'b0}};
          lane_r     <= 3'd0;
          sop_pend_r <= 1'b0;
        end else begin
          acc_r      <= put_byte(acc_r, lane_r, byte_data);
          lane_r     <= lane_r + 3'd1;
          sop_pend_r <= sop_pend_r | first_of_pkt;
        end
      end
    end
  end

endmodule

// File: rtl/rx_pkt_gen_rd_ctrl.sv
// rx_pkt_gen_rd_ctrl
// Read-side sequencer: fetches a packet image from RAM port B one byte per
// cycle, packs it into 64-bit MAC RX words and repeats it pkt_count times with
// IPG_CYCLES idle cycles between repetitions.
// Ports:
//   clk, reset         : clock (also RAM clk_b), synchronous active-high reset
//   start              : launch pulse, honoured only when idle
//   pkt_addr/len/count : packet start address, byte length, repetitions
//   busy, done         : run in progress / one-cycle completion pulse
//   ram_en/we/addr     : RAM port B controls (we is always 0)
//   ram_dout           : RAM port B read data, 2-cycle latency
//   rx                 : MAC RX word bus (master side)
module rx_pkt_gen_rd_ctrl
  import rx_pkt_gen_rd_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int IPG_CYCLES = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] pkt_addr,
  input  logic [ADDR_WIDTH-1:0] pkt_len,
  input  logic [7:0]            pkt_count,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  rx_pkt_gen_rd_ctrl_if.master  rx
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_A   = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ONE_A    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic                  GAP_NONE = (IPG_CYCLES == 0);
  localparam logic [7:0]            GAP_LOAD = (IPG_CYCLES > 0) ? 8'(IPG_CYCLES - 1) : 8'd0;

  logic [1:0]            state_r;
  logic [ADDR_WIDTH-1:0] base_r;
  logic [ADDR_WIDTH-1:0] len_r;
  logic [7:0]            rem_cnt_r;
  logic [ADDR_WIDTH-1:0] issue_rem_r;
  logic [7:0]            gap_cnt_r;
  logic                  first_r;
  logic [RD_LATENCY-1:0] vld_pipe_r;
  logic [RD_LATENCY-1:0] last_pipe_r;
  logic [RD_LATENCY-1:0] first_pipe_r;

  logic [WORD_W-1:0] pk_data_s;
  logic              pk_val_s;
  logic              pk_sop_s;
  logic              pk_eop_s;
  logic [2:0]        pk_mod_s;
  logic              eop_seen_s;

  assign ram_we     = 1'b0;
  assign eop_seen_s = pk_val_s & pk_eop_s;

  // FSM, issue/repetition/gap counters and the read-latency valid pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      base_r       <= ZERO_A;
      len_r        <= ZERO_A;
      rem_cnt_r    <= 8'd0;
      issue_rem_r  <= ZERO_A;
      gap_cnt_r    <= 8'd0;
      first_r      <= 1'b0;
      vld_pipe_r   <= {RD_LATENCY{1'b0}};
      last_pipe_r  <= {RD_LATENCY{1'b0}};
      first_pipe_r <= {RD_LATENCY{1'b0}};
      busy         <= 1'b0;
      done         <= 1'b0;
      ram_en       <= 1'b0;
      ram_addr     <= ZERO_A;
    end else begin
      done <= 1'b0;
      // Flags travel with each issued read so the packer sees them with its byte.
      vld_pipe_r   <= {vld_pipe_r[0], ram_en};
      last_pipe_r  <= {last_pipe_r[0], ram_en && (issue_rem_r == ZERO_A)};
      first_pipe_r <= {first_pipe_r[0], ram_en && first_r};
      case (state_r)
        ST_IDLE: begin
          if (start && (pkt_len != ZERO_A) && (pkt_count != 8'd0)) begin
            base_r      <= pkt_addr;
            len_r       <= pkt_len;
            rem_cnt_r   <= pkt_count;
            busy        <= 1'b1;
            state_r     <= ST_READ;
            ram_en      <= 1'b1;
            ram_addr    <= pkt_addr;
            issue_rem_r <= pkt_len - ONE_A;
            first_r     <= 1'b1;
          end
        end
        ST_READ: begin
          first_r <= 1'b0;
          if (issue_rem_r == ZERO_A) begin
            ram_en  <= 1'b0;
            state_r <= ST_DRAIN;
          end else begin
            ram_addr    <= ram_addr + ONE_A;
            issue_rem_r <= issue_rem_r - ONE_A;
          end
        end
        ST_DRAIN: begin
          if (eop_seen_s) begin
            rem_cnt_r <= rem_cnt_r - 8'd1;
            if (rem_cnt_r == 8'd1) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              state_r <= ST_IDLE;
            end else if (GAP_NONE) begin
              state_r     <= ST_READ;
              ram_en      <= 1'b1;
              ram_addr    <= base_r;
              issue_rem_r <= len_r - ONE_A;
              first_r     <= 1'b1;
            end else begin
              gap_cnt_r <= GAP_LOAD;
              state_r   <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == 8'd0) begin
            state_r     <= ST_READ;
            ram_en      <= 1'b1;
            ram_addr    <= base_r;
            issue_rem_r <= len_r - ONE_A;
            first_r     <= 1'b1;
          end else begin
            gap_cnt_r <= gap_cnt_r - 8'd1;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  rx_pkt_byte_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .byte_val     (vld_pipe_r[RD_LATENCY-1]),
    .byte_data    (ram_dout[7:0]),
    .byte_last    (last_pipe_r[RD_LATENCY-1]),
    .first_of_pkt (first_pipe_r[RD_LATENCY-1]),
    .rx_data      (pk_data_s),
    .rx_val       (pk_val_s),
    .rx_sop       (pk_sop_s),
    .rx_eop       (pk_eop_s),
    .rx_mod       (pk_mod_s)
  );

  assign rx.rx_data = pk_data_s;
  assign rx.rx_val  = pk_val_s;
  assign rx.rx_sop  = pk_sop_s;
  assign rx.rx_eop  = pk_eop_s;
  assign rx.rx_mod  = pk_mod_s;

endmodule

// File: doc/rx_pkt_gen_rd_ctrl.md
# rx_pkt_gen_rd_ctrl

Read-side sequencer for the PHY emulator receive path. It fetches a packet image byte-by-byte from port B of the 2K x 8 packet RAM and packs the bytes into 64-bit words. It presents those words to the MAC RX input with SOP/EOP/byte-count framing and repeats the packet a programmed number of times, separated by an idle gap. Port A of the RAM stays with the host loader.

## Interface
Parameters:
- ADDR_WIDTH, 11, RAM address width; addresses wrap modulo 2**ADDR_WIDTH.
- DATA_WIDTH, 8, RAM data width; fixed at 8, since the packer assumes bytes.
- IPG_CYCLES, 12, idle cycles between repetitions; legal range 0..255.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  single clock; also drives RAM port B clk_b.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse that launches a run; sampled only in IDLE.
- pkt_addr  in  ADDR_WIDTH  RAM address of byte 0; latched on start.
- pkt_len  in  ADDR_WIDTH  packet length in bytes, 1..2047; latched on start.
- pkt_count  in  8  number of repetitions, 1..255; latched on start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last EOP of the run.
- ram_en  out  1  to RAM en_b.
- ram_we  out  1  to RAM we_b; constant 0.
- ram_addr  out  ADDR_WIDTH  to RAM addr_b.
- ram_dout  in  DATA_WIDTH  from RAM dout_b; 2-cycle read latency.
- rx_data  out  64  packed word; byte 0 of each word is in [7:0].
- rx_val  out  1  rx_data is valid this cycle.
- rx_sop  out  1  first word of a packet; qualified by rx_val.
- rx_eop  out  1  last word of a packet; qualified by rx_val.
- rx_mod  out  3  valid bytes in the EOP word; 0 means 8. Meaningful only with rx_eop.

## Operation
- States are IDLE, READ, DRAIN and GAP.
- IDLE: on start with pkt_len != 0 and pkt_count != 0, latch the inputs, set rem_cnt = pkt_count, and go to READ. Otherwise the start is ignored and no busy or done is produced.
- READ: assert ram_en for exactly pkt_len consecutive cycles, with ram_addr = pkt_addr + i (i = 0..len-1, modulo 2**ADDR_WIDTH). After the last issue, go to DRAIN.
- Read-valid tracking: a 2-stage valid shift register tracks outstanding reads. Byte i is captured from ram_dout 2 cycles after its issue cycle.
- Packer, lane placement: captured byte n goes to lane n mod 8.
- Packer, word emission: when lane 7 is filled, or the captured byte is byte len-1, the word is emitted on the next cycle.
- Packer, unused lanes: lanes not filled in the EOP word are driven 0.
- Framing: rx_sop is set on the first word of each repetition. rx_eop is set on the word holding byte len-1. rx_mod = pkt_len[2:0].
- DRAIN: wait until the EOP word has been emitted, then decrement rem_cnt.
  - If rem_cnt becomes 0: pulse done in the cycle after EOP, drop busy in that same cycle, and return to IDLE. No gap follows the last repetition.
  - Otherwise: go to GAP.
- GAP: count IPG_CYCLES cycles with no ram_en and no rx_val, then return to READ from the latched pkt_addr. With IPG_CYCLES = 0, READ starts in the cycle after EOP.
- Start while busy: ignored. Latched parameters do not change during a run.
- There is no backpressure; the MAC RX input always accepts.

## Timing
- Reset values: busy, done, ram_en, ram_we, rx_val, rx_sop and rx_eop are 0; ram_addr, rx_data and rx_mod are 0. The FSM is in IDLE and rem_cnt is 0.
- Reset mid-run: all outputs drop in the next cycle. Packer contents are discarded. No done is generated.
- Start accepted at cycle 0:
  - busy is high from cycle 1.
  - Byte i is issued in cycle 1+i and captured at the end of cycle 3+i.
  - Word j (not the last) has rx_val in cycle 11+8j.
  - The EOP word has rx_val in cycle L+3, for L = pkt_len.
  - done is high in cycle L+4, and busy is low from cycle L+4.
- Repetitions: the next repetition's first ram_en comes IPG_CYCLES+1 cycles after the EOP cycle. There is no rx_val in between.
- Collision with port A: not checked here; the loader must not write during busy.

## Structure
- Shared include file rx_pkt_gen_defs.vh holds:
  - state encodings: IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2, GAP = 2'd3;
  - RAM read latency constant = 2;
  - output word width = 64 and lane count = 8.
- Sub-module rx_pkt_byte_packer:
  - inputs: clk, reset, byte_val, byte, byte_last, first_of_pkt;
  - outputs: rx_data, rx_val, rx_sop, rx_eop, rx_mod.
- Top level contains the FSM, address/length/repetition counters and the read-latency valid pipe.

## Test plan
- Single packet, 64 bytes at address 0x000 holding values 0x00..0x3F, count 1. Required: 8 words; word 0 = 0x0706050403020100 with SOP at cycle 11; EOP at cycle 67 with rx_mod = 0; done at cycle 68.
- 1-byte packet, value 0xA5, count 1. Required: one word 0x00000000000000A5 at cycle 4 with SOP and EOP both set and rx_mod = 1; done at cycle 5.
- 13-byte packet at address 0x7FA. Required: ram_addr sequence 0x7FA..0x7FF, 0x000..0x006; second word has EOP with rx_mod = 5 and lanes 5..7 equal to 0.
- 20-byte packet, count 3, IPG_CYCLES 12. Required: three identical SOP..EOP sequences; exactly 12 cycles with no ram_en between each EOP and the next issue; a single done pulse.
- Start pulses while busy, and a start with pkt_len = 0. Required: the in-flight run is unaltered, and the pkt_len = 0 start produces no busy and no done.
- Reset asserted in cycle 30 of a 64-byte packet. Required: outputs are 0 in cycle 31, no done, and a new start afterwards runs cleanly from SOP.
